// File: rtl/ysyx_220053_ifu_pkg.sv
// ysyx_220053_ifu_pkg: shared types and constants for the handshaked IFU.
package ysyx_220053_ifu_pkg;
   localparam int XLEN = 64;
   localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
   typedef enum logic [1:0] {IDLE, REQ, WAIT, HALT} state_t;
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     instr;
      logic            fault;
   } fq_entry_t;
endpackage

// File: rtl/ysyx_220053_ifu_fifo.sv
// ysyx_220053_ifu_fifo: synchronous fetch queue of fq_entry_t; flush empties it in one cycle.
module ysyx_220053_ifu_fifo
   import ysyx_220053_ifu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         push,
   input  fq_entry_t                    din,
   input  logic                         pop,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output fq_entry_t                    head
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   fq_entry_t mem [DEPTH];
   logic [AW-1:0] rd, wr;
   assign head = mem[rd];
   always_ff @(posedge clk) begin
      if (push) mem[wr] <= din;
   end
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd <= '0;
         wr <= '0;
         count <= '0;
      end else begin
         if (push) wr <= wr + AW'(1);
         if (pop) rd <= rd + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end
endmodule

// File: rtl/ysyx_220053_ifu_hs.sv
// ysyx_220053_ifu_hs: handshaked fetch unit with epoch-tagged fetches and a fetch queue to IDU.
// Optional misaligned-PC fault check enabled by defining IFU_MISALIGN_CHK_EN.
module ysyx_220053_ifu_hs
   import ysyx_220053_ifu_pkg::*;
#(
   parameter int              MEM_W    = 64,
   parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000,
   parameter int              FQ_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             redirect_valid,
   input  logic [XLEN-1:0]  redirect_pc,
   output logic             mem_req_valid,
   input  logic             mem_req_ready,
   output logic [XLEN-1:0]  mem_req_addr,
   input  logic             mem_resp_valid,
   input  logic [MEM_W-1:0] mem_resp_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_pc,
   output logic [31:0]      out_instr,
   output logic             out_fault
);
   localparam int CW = $clog2(FQ_DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(FQ_DEPTH);
   state_t state;
   logic [XLEN-1:0] pc_q, req_pc;
   logic epoch, tag, misalign, accept, fault_push, push, pop;
   logic [CW-1:0] count, cnt_next;
   logic [63:0] data64;
   fq_entry_t din, head;
`ifdef IFU_MISALIGN_CHK_EN
   assign misalign = pc_q[1:0] != 2'b00;
`else
   assign misalign = 1'b0;
`endif
   assign out_valid = count != '0;
   assign out_pc    = out_valid ? head.pc : '0;
   assign out_instr = out_valid ? head.instr : '0;
   assign out_fault = out_valid && head.fault;
   // A response only counts if its tag matches the current epoch; redirect kills pushes that cycle.
   always_comb begin
      data64 = 64'(mem_resp_data);
      mem_req_valid = state == REQ && !misalign;
      mem_req_addr = pc_q;
      accept = mem_req_valid && mem_req_ready;
      fault_push = state == REQ && misalign && count < FULL;
      push = !redirect_valid && (fault_push || (state == WAIT && mem_resp_valid && tag == epoch));
      pop = out_valid && out_ready && !redirect_valid;
      din.pc = fault_push ? pc_q : req_pc;
      din.instr = fault_push ? INSTR_NOP : (MEM_W == 64 && req_pc[2]) ? data64[63:32] : data64[31:0];
      din.fault = fault_push;
      cnt_next = count + CW'(push) - CW'(pop);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         pc_q <= RESET_PC;
         req_pc <= RESET_PC;
         epoch <= 1'b0;
         tag <= 1'b0;
      end else begin
         if (accept) begin
            tag <= epoch;
            req_pc <= pc_q;
         end
         if (redirect_valid) begin
            pc_q <= redirect_pc;
            epoch <= ~epoch;
            // An outstanding or just-accepted fetch must still be drained in WAIT.
            state <= (accept || (state == WAIT && !mem_resp_valid)) ? WAIT : REQ;
         end else begin
            if (accept) pc_q <= pc_q + XLEN'(4);
            case (state)
               IDLE: state <= count < FULL ? REQ : IDLE;
               REQ: begin
                  if (accept) state <= WAIT;
`ifdef IFU_MISALIGN_CHK_EN
                  else if (fault_push) state <= HALT;
`endif
               end
               WAIT: if (mem_resp_valid) state <= cnt_next < FULL ? REQ : IDLE;
               default: state <= state;
            endcase
         end
      end
   end
   ysyx_220053_ifu_fifo #(.DEPTH(FQ_DEPTH)) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .flush(redirect_valid),
      .push (push),
      .din  (din),
      .pop  (pop),
      .count(count),
      .head (head)
   );
endmodule

// File: tb/tb_ysyx_220053_ifu_hs.sv
// tb_ysyx_220053_ifu_hs: directed bench with a one-cycle-latency memory model and an IDU pop monitor.
module tb_ysyx_220053_ifu_hs;
   import ysyx_220053_ifu_pkg::*;
   logic clk, rst, redirect_valid, mem_req_valid, mem_req_ready, mem_resp_valid;
   logic out_valid, out_ready, out_fault, resp_en, pend;
   logic [63:0] redirect_pc, mem_req_addr, mem_resp_data, out_pc, pend_addr;
   logic [31:0] out_instr;
   int ntest = 0, nfail = 0;
   fq_entry_t pop_q[$];
   logic [63:0] req_log[$];

   ysyx_220053_ifu_hs dut (
      .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_instr(out_instr), .out_fault(out_fault)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] word_at(input logic [63:0] a);
      return a[31:0] ^ 32'h1357_9BDF;
   endfunction

   // Memory: answers each accepted request one cycle later (held while resp_en=0).
   initial begin
      pend = 0;
      pend_addr = 0;
      mem_resp_valid = 0;
      mem_resp_data = 0;
      forever begin
         @(negedge clk);
         mem_resp_valid = 0;
         if (pend && resp_en) begin
            mem_resp_valid = 1;
            mem_resp_data = {word_at((pend_addr & ~64'h7) + 64'd4), word_at(pend_addr & ~64'h7)};
            pend = 0;
         end
         if (mem_req_valid && mem_req_ready) begin
            pend = 1;
            pend_addr = mem_req_addr;
            req_log.push_back(mem_req_addr);
         end
         if (!rst && out_valid && out_ready && !redirect_valid)
            pop_q.push_back('{pc: out_pc, instr: out_instr, fault: out_fault});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ntest++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1;
      redirect_valid = 0;
      step();
      step();
      pop_q.delete();
      req_log.delete();
      rst = 0;
   endtask

   initial begin
      rst = 1;
      redirect_valid = 0;
      redirect_pc = 0;
      mem_req_ready = 1;
      out_ready = 1;
      resp_en = 1;
      step();
      step();
      check("rst_out_valid", 64'(out_valid), 0);
      check("rst_req_valid", 64'(mem_req_valid), 0);
      check("rst_req_addr", mem_req_addr, 64'h8000_0000);
      check("rst_out_pc", out_pc, 0);
      check("rst_out_instr", 64'(out_instr), 0);
      check("rst_out_fault", 64'(out_fault), 0);
      pop_q.delete();
      req_log.delete();
      rst = 0;
      // 1: streaming fetch
      for (int i = 0; i < 60 && pop_q.size() < 3; i++) step();
      check("t1_wait", 64'(pop_q.size() >= 3), 1);
      check("t1_pc0", pop_q[0].pc, 64'h8000_0000);
      check("t1_in0", 64'(pop_q[0].instr), 64'h9357_9BDF);
      check("t1_pc1", pop_q[1].pc, 64'h8000_0004);
      check("t1_in1", 64'(pop_q[1].instr), 64'h9357_9BDB);
      check("t1_pc2", pop_q[2].pc, 64'h8000_0008);
      check("t1_in2", 64'(pop_q[2].instr), 64'h9357_9BD7);
      // 2: backpressure fills the queue, then fetching stops
      out_ready = 0;
      do_reset();
      repeat (20) step();
      check("t2_nreq", 64'(req_log.size()), 4);
      check("t2_req3", req_log[3], 64'h8000_000C);
      check("t2_req_valid", 64'(mem_req_valid), 0);
      check("t2_head_pc", out_pc, 64'h8000_0000);
      out_ready = 1;
      for (int i = 0; i < 30 && req_log.size() < 5; i++) step();
      check("t2_resume", req_log[4], 64'h8000_0010);
      // 3: redirect while waiting on memory
      resp_en = 0;
      do_reset();
      for (int i = 0; i < 20 && req_log.size() < 1; i++) step();
      redirect_valid = 1;
      redirect_pc = 64'h8000_1000;
      step();
      redirect_valid = 0;
      resp_en = 1;
      step();
      check("t3_empty", 64'(out_valid), 0);
      check("t3_req_valid", 64'(mem_req_valid), 1);
      check("t3_req_addr", mem_req_addr, 64'h8000_1000);
      for (int i = 0; i < 30 && pop_q.size() < 1; i++) step();
      check("t3_pc", pop_q[0].pc, 64'h8000_1000);
      check("t3_instr", 64'(pop_q[0].instr), 64'h9357_8BDF);
      // 4: redirect coincides with request accept and a pop
      out_ready = 0;
      do_reset();
      for (int i = 0; i < 20 && out_valid !== 1'b1; i++) step();
      check("t4_setup", 64'(mem_req_valid), 1);
      out_ready = 1;
      redirect_valid = 1;
      redirect_pc = 64'h8000_2000;
      step();
      redirect_valid = 0;
      check("t4_no_pop", 64'(pop_q.size()), 0);
      check("t4_flushed", 64'(out_valid), 0);
      for (int i = 0; i < 30 && pop_q.size() < 1; i++) step();
      check("t4_pc", pop_q[0].pc, 64'h8000_2000);
      check("t4_instr", 64'(pop_q[0].instr), 64'h9357_BBDF);
      check("t4_killed_req", req_log[1], 64'h8000_0004);
      check("t4_refetch", req_log[2], 64'h8000_2000);
      // 5: upper half of a 64-bit word
      do_reset();
      redirect_valid = 1;
      redirect_pc = 64'h8000_0004;
      step();
      redirect_valid = 0;
      for (int i = 0; i < 30 && pop_q.size() < 1; i++) step();
      check("t5_req", req_log[0], 64'h8000_0004);
      check("t5_pc", pop_q[0].pc, 64'h8000_0004);
      check("t5_instr", 64'(pop_q[0].instr), 64'h9357_9BDB);
      // 6: misaligned redirect target
      do_reset();
      redirect_valid = 1;
      redirect_pc = 64'h8000_0002;
      step();
      redirect_valid = 0;
`ifdef IFU_MISALIGN_CHK_EN
      repeat (10) step();
      check("t6_noreq", 64'(req_log.size()), 0);
      check("t6_halt", 64'(mem_req_valid), 0);
      check("t6_pc", pop_q[0].pc, 64'h8000_0002);
      check("t6_fault", 64'(pop_q[0].fault), 1);
      check("t6_instr", 64'(pop_q[0].instr), 64'h0000_0013);
      redirect_valid = 1;
      redirect_pc = 64'h8000_0000;
      step();
      redirect_valid = 0;
      for (int i = 0; i < 30 && pop_q.size() < 2; i++) step();
      check("t6_leave", pop_q[1].pc, 64'h8000_0000);
`else
      for (int i = 0; i < 30 && pop_q.size() < 1; i++) step();
      check("t6_req", req_log[0], 64'h8000_0002);
      check("t6_pc", pop_q[0].pc, 64'h8000_0002);
      check("t6_instr", 64'(pop_q[0].instr), 64'h9357_9BDF);
      check("t6_fault", 64'(pop_q[0].fault), 0);
`endif
      $display("[TB] %0d tests run, %0d failed", ntest, nfail);
      $finish;
   end
endmodule
